// File: rtl/dpram_bist_pkg.sv
// Shared types and constants for the dual-port RAM march BIST controller.
// Holds the FSM state encoding, pattern selector codes and default widths.
// No logic lives here; the controller and compare stage import it.
package dpram_bist_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 6;
  localparam int CNT_W_DEF  = 8;

  // pattern_sel encodings; code 3 falls through to solid
  localparam logic [1:0] PAT_SOLID   = 2'd0;
  localparam logic [1:0] PAT_CHECKER = 2'd1;
  localparam logic [1:0] PAT_ADDR    = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR0,
    ST_RD0,
    ST_DRN0,
    ST_WR1,
    ST_RD1,
    ST_DRN1,
    ST_DONE
  } bist_state_t;

endpackage

// File: rtl/dpram_bist_cmp.sv
// Read-compare stage: holds expected data/address for one cycle while the RAM reads.
// Latency: compare result lands one cycle after data_out is valid (two after re).
// No backpressure; every read issued is compared exactly once.
module dpram_bist_cmp
  import dpram_bist_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              rd_vld,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_exp,
  input  logic [DATA_W-1:0] rd_dat,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_exp,
  output logic [DATA_W-1:0] fail_got,
  output logic [CNT_W-1:0]  err_count,
  output logic              clean_next
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              pipe_vld;
  logic [ADDR_W-1:0] pipe_addr;
  logic [DATA_W-1:0] pipe_exp;
  logic              mismatch;

  // RAM data_out arrives the cycle after the read, aligned with the pipe register
  assign mismatch   = pipe_vld && (rd_dat != pipe_exp);
  // Lets the controller report pass in the same cycle the final compare lands
  assign clean_next = (err_count == '0) && !mismatch;

  // Pipe the read context, count mismatches and capture only the first failure
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pipe_vld  <= 1'b0;
      pipe_addr <= '0;
      pipe_exp  <= '0;
      fail_addr <= '0;
      fail_exp  <= '0;
      fail_got  <= '0;
      err_count <= '0;
    end else if (clr) begin
      pipe_vld  <= 1'b0;
      pipe_addr <= '0;
      pipe_exp  <= '0;
      fail_addr <= '0;
      fail_exp  <= '0;
      fail_got  <= '0;
      err_count <= '0;
    end else begin
      pipe_vld  <= rd_vld;
      pipe_addr <= rd_addr;
      pipe_exp  <= rd_exp;
      if (mismatch) begin
        if (err_count != CNT_MAX) begin
          err_count <= err_count + CNT_W'(1);
        end
        if (err_count == '0) begin
          fail_addr <= pipe_addr;
          fail_exp  <= pipe_exp;
          fail_got  <= rd_dat;
        end
      end
    end
  end

endmodule

// File: rtl/dpram_bist_ctrl.sv
// March BIST initiator for the dual-port RAM: write P0, read P0, write ~P0, read ~P0.
// Latency: done pulses 4*DEPTH+3 cycles after start is accepted.
// No backpressure; start is only honoured in IDLE and ignored while busy.
module dpram_bist_ctrl
  import dpram_bist_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        pattern_sel,
  output logic [DATA_W-1:0] mem_data_in,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_rd_addr,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_exp,
  output logic [DATA_W-1:0] fail_got,
  output logic [CNT_W-1:0]  err_count
);

  localparam logic [ADDR_W-1:0] LAST = '1;

  bist_state_t       state;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] cnt_nxt;
  logic [1:0]        sel_q;
  logic              accept;
  logic [DATA_W-1:0] rd_exp;
  logic              clean_next;

  // Background value for address a; inv selects the complement phase
  function automatic logic [DATA_W-1:0] pat_val(input logic [1:0] sel, input logic inv,
                                                input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] v;
    v = '0;
    case (sel)
      PAT_CHECKER: begin
        for (int i = 0; i < DATA_W; i++) begin
          v[i] = ((i % 2) == 0) ? ~a[0] : a[0];
        end
      end
      PAT_ADDR: v = DATA_W'(a);
      default:  v = '0;
    endcase
    return inv ? ~v : v;
  endfunction

  assign accept  = (state == ST_IDLE) && start;
  assign cnt_nxt = cnt + ADDR_W'(1);
  // Expected value follows the registered read address so it pipes with the read
  assign rd_exp  = pat_val(sel_q, state == ST_RD1, mem_rd_addr);

  // Sequencer: state, address counter and all RAM-side/status outputs registered
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      sel_q       <= PAT_SOLID;
      mem_data_in <= '0;
      mem_wr_addr <= '0;
      mem_we      <= 1'b0;
      mem_rd_addr <= '0;
      mem_re      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            sel_q       <= pattern_sel;
            cnt         <= '0;
            pass        <= 1'b0;
            busy        <= 1'b1;
            mem_we      <= 1'b1;
            mem_wr_addr <= '0;
            mem_data_in <= pat_val(pattern_sel, 1'b0, '0);
            state       <= ST_WR0;
          end
        end
        ST_WR0, ST_WR1: begin
          if (cnt == LAST) begin
            cnt         <= '0;
            mem_we      <= 1'b0;
            mem_re      <= 1'b1;
            mem_rd_addr <= '0;
            state       <= (state == ST_WR0) ? ST_RD0 : ST_RD1;
          end else begin
            cnt         <= cnt_nxt;
            mem_wr_addr <= cnt_nxt;
            mem_data_in <= pat_val(sel_q, state == ST_WR1, cnt_nxt);
          end
        end
        ST_RD0, ST_RD1: begin
          if (cnt == LAST) begin
            cnt    <= '0;
            mem_re <= 1'b0;
            state  <= (state == ST_RD0) ? ST_DRN0 : ST_DRN1;
          end else begin
            cnt         <= cnt_nxt;
            mem_rd_addr <= cnt_nxt;
          end
        end
        ST_DRN0: begin
          mem_we      <= 1'b1;
          mem_wr_addr <= '0;
          mem_data_in <= pat_val(sel_q, 1'b1, '0);
          state       <= ST_WR1;
        end
        ST_DRN1: begin
          done  <= 1'b1;
          pass  <= clean_next;
          state <= ST_DONE;
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          mem_we <= 1'b0;
          mem_re <= 1'b0;
          busy   <= 1'b0;
          done   <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

  dpram_bist_cmp #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .CNT_W (CNT_W)
  ) u_cmp (
    .clk       (clk),
    .reset     (reset),
    .clr       (accept),
    .rd_vld    (mem_re),
    .rd_addr   (mem_rd_addr),
    .rd_exp    (rd_exp),
    .rd_dat    (mem_data_out),
    .fail_addr (fail_addr),
    .fail_exp  (fail_exp),
    .fail_got  (fail_got),
    .err_count (err_count),
    .clean_next(clean_next)
  );

endmodule

// File: tb/tb_dpram_bist_ctrl.sv
// Bench for dpram_bist_ctrl: behavioural 64x8 RAM with injectable read faults,
// a cycle-offset model of the march schedule and results, and a per-cycle compare.
// Directed scenarios pin literal values; a randomized loop covers the rest.
module tb_dpram_bist_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [1:0] pattern_sel = 2'd0;
  logic [7:0] mem_data_in;
  logic [5:0] mem_wr_addr;
  logic       mem_we;
  logic [5:0] mem_rd_addr;
  logic       mem_re;
  logic [7:0] mem_data_out = 8'h00;
  logic       busy, done, pass;
  logic [5:0] fail_addr;
  logic [7:0] fail_exp, fail_got;
  logic [7:0] err_count;

  dpram_bist_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .pattern_sel(pattern_sel),
    .mem_data_in(mem_data_in), .mem_wr_addr(mem_wr_addr), .mem_we(mem_we),
    .mem_rd_addr(mem_rd_addr), .mem_re(mem_re), .mem_data_out(mem_data_out),
    .busy(busy), .done(done), .pass(pass), .fail_addr(fail_addr),
    .fail_exp(fail_exp), .fail_got(fail_got), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Spec-level pattern: value written to address a in phase ph (1 = inverse)
  function automatic int pat(input int sel, input int ph, input int a);
    int v;
    case (sel)
      1:       v = (a % 2 == 1) ? 'hAA : 'h55;
      2:       v = a;
      default: v = 0;
    endcase
    if (ph != 0) v = v ^ 'hFF;
    return v;
  endfunction

  // Read fault: 1 = stuck-at-1 on one bit of one address, 2 = every read inverted
  function automatic int flt(input int mode, input int fa, input int fb, input int a, input int v);
    case (mode)
      1:       return (a == fa) ? (v | (1 << fb)) : v;
      2:       return v ^ 'hFF;
      default: return v;
    endcase
  endfunction

  // Environment RAM: synchronous read, data valid the cycle after re
  logic [7:0] ram [64];
  int f_mode = 0, f_addr = 0, f_bit = 0;
  always @(posedge clk) begin
    if (mem_we) ram[mem_wr_addr] <= mem_data_in;
    if (mem_re) mem_data_out <= 8'(flt(f_mode, f_addr, f_bit, int'(mem_rd_addr), int'(ram[mem_rd_addr])));
  end

  // Model: m_t = cycles since the accepting edge (1 = first WR0 cycle), 0 = none since reset
  int m_t = 0, m_sel = 0, m_fmode = 0, m_faddr = 0, m_fbit = 0;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_t <= 0;
    end else if (!(m_t >= 1 && m_t <= 259) && start) begin
      m_t     <= 1;
      m_sel   <= (int'(pattern_sel) == 3) ? 0 : int'(pattern_sel);
      m_fmode <= f_mode;
      m_faddr <= f_addr;
      m_fbit  <= f_bit;
    end else if (m_t > 0) begin
      m_t <= m_t + 1;
    end
  end

  typedef struct packed {
    bit busy, done, we, re, pass;
    int wa, wd, ra, err, fa, fe, fg;
  } exp_t;

  function automatic exp_t model_at(input int t);
    exp_t e;
    int   tot, ev, gv, vis;
    e = '0;
    if (t == 0) return e;
    e.busy = (t >= 1 && t <= 259);
    e.done = (t == 259);
    e.we   = (t >= 1 && t <= 64) || (t >= 130 && t <= 193);
    e.wa   = (t <= 64) ? t - 1 : t - 130;
    e.wd   = pat(m_sel, (t >= 130) ? 1 : 0, e.wa);
    e.re   = (t >= 65 && t <= 128) || (t >= 194 && t <= 257);
    e.ra   = (t <= 128) ? t - 65 : t - 194;
    tot = 0;
    for (int ph = 0; ph < 2; ph++) begin
      for (int a = 0; a < 64; a++) begin
        ev  = pat(m_sel, ph, a);
        gv  = flt(m_fmode, m_faddr, m_fbit, a, ev);
        vis = ((ph == 0) ? 67 : 196) + a;
        if (gv != ev) begin
          tot++;
          if (t >= vis) begin
            if (e.err == 0) begin
              e.fa = a;
              e.fe = ev;
              e.fg = gv;
            end
            if (e.err < 255) e.err = e.err + 1;
          end
        end
      end
    end
    e.pass = (t >= 259) && (tot == 0);
    return e;
  endfunction

  // Per-cycle compare of every output against the model; also logs the write bus
  logic [7:0] wlog [2][64];
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      e = model_at(m_t);
      chk("busy", int'(busy), int'(e.busy));
      chk("done", int'(done), int'(e.done));
      chk("we", int'(mem_we), int'(e.we));
      chk("re", int'(mem_re), int'(e.re));
      chk("we_re_excl", int'(mem_we & mem_re), 0);
      if (e.we) begin
        chk("wr_addr", int'(mem_wr_addr), e.wa);
        chk("wr_data", int'(mem_data_in), e.wd);
        wlog[(m_t >= 130) ? 1 : 0][e.wa] = mem_data_in;
      end
      if (e.re) chk("rd_addr", int'(mem_rd_addr), e.ra);
      chk("err_count", int'(err_count), e.err);
      chk("fail_addr", int'(fail_addr), e.fa);
      chk("fail_exp", int'(fail_exp), e.fe);
      chk("fail_got", int'(fail_got), e.fg);
      chk("pass", int'(pass), int'(e.pass));
    end
  end

  // Pulse start, wait (bounded) for done; lat = cycles from accept to done
  task automatic run_test(input int sel, input bit noise, output int lat);
    @(negedge clk);
    pattern_sel = 2'(sel);
    start = 1'b1;
    lat = -1;
    for (int n = 1; n <= 400; n++) begin
      @(negedge clk);
      if (done) begin
        lat = n;
        break;
      end
      start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      if (noise) pattern_sel = 2'($urandom_range(0, 3));
    end
    start = 1'b0;
    chk("done_latency", lat, 259);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_pass", int'(pass), 0);
    chk("rst_we", int'(mem_we), 0);
    chk("rst_re", int'(mem_re), 0);
    chk("rst_wr_addr", int'(mem_wr_addr), 0);
    chk("rst_data_in", int'(mem_data_in), 0);
    chk("rst_err", int'(err_count), 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Solid pattern, healthy RAM
    run_test(0, 1'b0, lat);
    chk("a_pass", int'(pass), 1);
    chk("a_err", int'(err_count), 0);
    chk("a_w0_0", int'(wlog[0][0]), 'h00);
    chk("a_w1_63", int'(wlog[1][63]), 'hFF);
    @(negedge clk);

    // Checkerboard with bit3 stuck-at-1 at 0x2A
    f_mode = 1; f_addr = 'h2A; f_bit = 3;
    run_test(1, 1'b0, lat);
    chk("b_fail_addr", int'(fail_addr), 'h2A);
    chk("b_fail_exp", int'(fail_exp), 'h55);
    chk("b_fail_got", int'(fail_got), 'h5D);
    chk("b_err", int'(err_count), 1);
    chk("b_pass", int'(pass), 0);
    f_mode = 0;
    repeat (3) @(negedge clk);

    // Address-as-data
    run_test(2, 1'b0, lat);
    chk("c_w0_5", int'(wlog[0][5]), 'h05);
    chk("c_w1_5", int'(wlog[1][5]), 'hFA);
    chk("c_w0_63", int'(wlog[0][63]), 'h3F);
    chk("c_w1_63", int'(wlog[1][63]), 'hC0);
    chk("c_pass", int'(pass), 1);

    // Every read corrupted, start/pattern_sel toggling while busy
    f_mode = 2;
    run_test(int'($urandom_range(0, 3)), 1'b1, lat);
    chk("d_err", int'(err_count), 128);
    chk("d_fail_addr", int'(fail_addr), 0);
    chk("d_pass", int'(pass), 0);
    f_mode = 0;
    repeat (2) @(negedge clk);

    // Reset at N+100 (mid RD0)
    pattern_sel = 2'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (99) @(negedge clk);
    chk("e_pre_re", int'(mem_re), 1);
    #2 reset = 1'b0;
    #1;
    chk("e_async_we", int'(mem_we), 0);
    chk("e_async_re", int'(mem_re), 0);
    chk("e_async_busy", int'(busy), 0);
    repeat (3) @(negedge clk);
    chk("e_done", int'(done), 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    run_test(1, 1'b0, lat);
    chk("e_pass", int'(pass), 1);

    // Back-to-back: failing run, then start in the cycle after done
    f_mode = 1; f_addr = int'($urandom_range(0, 63)); f_bit = int'($urandom_range(0, 7));
    run_test(1, 1'b0, lat);
    chk("f1_err", int'(err_count), 1);
    chk("f1_fail_addr", int'(fail_addr), f_addr);
    f_mode = 0;
    run_test(2, 1'b0, lat);
    chk("f2_pass", int'(pass), 1);
    chk("f2_fail_addr", int'(fail_addr), 0);

    // Randomized runs
    for (int k = 0; k < 5; k++) begin
      f_mode = int'($urandom_range(0, 2));
      f_addr = int'($urandom_range(0, 63));
      f_bit  = int'($urandom_range(0, 7));
      repeat ($urandom_range(1, 5)) @(negedge clk);
      run_test(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), lat);
    end
    f_mode = 0;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
